// File: rtl/LDPC_pkg.sv
// rtl/LDPC_pkg.sv - shared LDPC constants and desegmenter state type
package LDPC_pkg;
  localparam int MAX_ZC     = 384;
  localparam int CB_CRC_LEN = 24;
  localparam int MAX_CB     = 8;
  localparam int ACC_W      = 2 * MAX_ZC;
  localparam int CNT_W      = 10;

  typedef enum logic [1:0] {DS_IDLE, DS_COLLECT, DS_FLUSH} deseg_state_t;
endpackage

// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - variable-length append into a 2*MAX_ZC accumulator with word extract
// Bits above cnt are always zero, so the low word doubles as the zero-padded residual.
module bit_packer
  import LDPC_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [MAX_ZC-1:0] push_bits,
  input  logic [8:0]        push_len,
  input  logic              pop,
  output logic [MAX_ZC-1:0] word,
  output logic [CNT_W-1:0]  cnt,
  output logic              full
);
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  sum_cnt;
  logic [MAX_ZC-1:0] masked;

  always_comb begin
    masked  = push ? (push_bits & ~({MAX_ZC{1'b1}} << push_len)) : '0;
    sum     = acc | ({{MAX_ZC{1'b0}}, masked} << cnt);
    sum_cnt = cnt + (push ? CNT_W'(push_len) : '0);
    word    = sum[MAX_ZC-1:0];
    full    = sum_cnt >= CNT_W'(MAX_ZC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (pop) begin
      acc <= sum >> MAX_ZC;
      cnt <= sum_cnt - CNT_W'(MAX_ZC);
    end else begin
      acc <= sum;
      cnt <= sum_cnt;
    end
  end
endmodule

// File: rtl/post_decoder_desegmenter.sv
// rtl/post_decoder_desegmenter.sv - strips fillers/CB-CRC from decoded columns and packs TB words
module post_decoder_desegmenter
  import LDPC_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              params_valid,
  input  logic [8:0]        zc,
  input  logic [4:0]        kb,
  input  logic [3:0]        num_cb,
  input  logic [13:0]       k_prime,
  input  logic [MAX_ZC-1:0] dec_block,
  input  logic              dec_valid,
  output logic              dec_ready,
  output logic [MAX_ZC-1:0] tb_block,
  output logic              tb_valid,
  input  logic              tb_ready,
  output logic              tb_last,
  output logic [8:0]        tb_last_bits,
  output logic              busy,
  output logic              param_err
);
  deseg_state_t      state, state_next;
  logic [8:0]        zc_r;
  logic [4:0]        kb_r;
  logic [3:0]        num_cb_r;
  logic [13:0]       keep_r;
  logic [16:0]       total_r, sent_r;
  logic [4:0]        col;
  logic [3:0]        cb;
  logic [14:0]       cap;
  logic [13:0]       crc_len, keep_in, b, diff;
  logic [8:0]        n;
  logic              params_ok, load_params, accept, last_col, out_free;
  logic              pop, pop_last, flush_load, full;
  logic [MAX_ZC-1:0] word;
  logic [CNT_W-1:0]  acc_cnt;

  assign out_free  = !tb_valid || tb_ready;
  assign dec_ready = (state == DS_COLLECT) && out_free && (acc_cnt < CNT_W'(MAX_ZC));
  assign busy      = (state != DS_IDLE);

  always_comb begin
    cap       = 15'(kb) * 15'(zc);
    crc_len   = (num_cb > 4'd1) ? 14'(CB_CRC_LEN) : 14'd0;
    keep_in   = k_prime - crc_len;
    params_ok = (zc != '0) && (kb != '0) && (num_cb != '0) && (num_cb <= 4'(MAX_CB))
                && ({1'b0, k_prime} <= cap) && (k_prime > crc_len);
    b         = 14'(col) * 14'(zc_r);
    diff      = keep_r - b;
    // Columns past the kept payload (CB-CRC, fillers) contribute nothing.
    if (keep_r <= b)             n = '0;
    else if (diff > 14'(zc_r))   n = zc_r;
    else                         n = diff[8:0];
    accept      = dec_valid && dec_ready;
    last_col    = (col == kb_r - 5'd1) && (cb == num_cb_r - 4'd1);
    pop         = (state == DS_COLLECT) && full && out_free;
    pop_last    = (sent_r + 17'(MAX_ZC)) == total_r;
    load_params = 1'b0;
    flush_load  = 1'b0;
    state_next  = state;
    case (state)
      DS_IDLE: begin
        if (params_valid && params_ok) begin
          load_params = 1'b1;
          state_next  = DS_COLLECT;
        end
      end
      DS_COLLECT: begin
        if (accept && last_col) state_next = DS_FLUSH;
      end
      DS_FLUSH: begin
        if (tb_valid && tb_last) begin
          if (tb_ready) state_next = DS_IDLE;
        end else if (acc_cnt != '0) begin
          if (out_free) flush_load = 1'b1;
        end else if (!tb_valid) begin
          state_next = DS_IDLE;
        end
      end
      default: state_next = DS_IDLE;
    endcase
  end

  bit_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (load_params || flush_load),
    .push      (accept),
    .push_bits (dec_block),
    .push_len  (n),
    .pop       (pop),
    .word      (word),
    .cnt       (acc_cnt),
    .full      (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= DS_IDLE;
      zc_r         <= '0;
      kb_r         <= '0;
      num_cb_r     <= '0;
      keep_r       <= '0;
      total_r      <= '0;
      sent_r       <= '0;
      col          <= '0;
      cb           <= '0;
      param_err    <= 1'b0;
      tb_block     <= '0;
      tb_valid     <= 1'b0;
      tb_last      <= 1'b0;
      tb_last_bits <= '0;
    end else begin
      state     <= state_next;
      param_err <= (state == DS_IDLE) && params_valid && !params_ok;
      if (load_params) begin
        zc_r     <= zc;
        kb_r     <= kb;
        num_cb_r <= num_cb;
        keep_r   <= keep_in;
        total_r  <= 17'(num_cb) * 17'(keep_in);
        sent_r   <= '0;
        col      <= '0;
        cb       <= '0;
      end else if (accept) begin
        if (col == kb_r - 5'd1) begin
          col <= '0;
          cb  <= cb + 4'd1;
        end else begin
          col <= col + 5'd1;
        end
      end
      // An exact multiple of MAX_ZC leaves no residual, so the final full word carries tb_last.
      if (pop) begin
        tb_block     <= word;
        tb_valid     <= 1'b1;
        tb_last      <= pop_last;
        tb_last_bits <= pop_last ? 9'(MAX_ZC) : 9'd0;
        sent_r       <= sent_r + 17'(MAX_ZC);
      end else if (flush_load) begin
        tb_block     <= word;
        tb_valid     <= 1'b1;
        tb_last      <= 1'b1;
        tb_last_bits <= acc_cnt[8:0];
      end else if (tb_ready) begin
        tb_valid     <= 1'b0;
        tb_last      <= 1'b0;
        tb_last_bits <= '0;
      end
    end
  end
endmodule

// File: tb/tb_post_decoder_desegmenter.sv
// tb/tb_post_decoder_desegmenter.sv - scoreboard bench for post_decoder_desegmenter
module tb_post_decoder_desegmenter;
  import LDPC_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              params_valid;
  logic [8:0]        zc;
  logic [4:0]        kb;
  logic [3:0]        num_cb;
  logic [13:0]       k_prime;
  logic [MAX_ZC-1:0] dec_block;
  logic              dec_valid;
  logic              dec_ready;
  logic [MAX_ZC-1:0] tb_block;
  logic              tb_valid;
  logic              tb_ready;
  logic              tb_last;
  logic [8:0]        tb_last_bits;
  logic              busy;
  logic              param_err;

  always #5 clk = ~clk;

  post_decoder_desegmenter dut (
    .clk(clk), .reset_n(reset_n), .params_valid(params_valid), .zc(zc), .kb(kb),
    .num_cb(num_cb), .k_prime(k_prime), .dec_block(dec_block), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .tb_block(tb_block), .tb_valid(tb_valid), .tb_ready(tb_ready),
    .tb_last(tb_last), .tb_last_bits(tb_last_bits), .busy(busy), .param_err(param_err)
  );

  typedef struct {
    logic [MAX_ZC-1:0] blk;
    logic              last;
    logic [8:0]        bits;
  } exp_t;

  exp_t exp_q[$];
  bit   model_bits[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   words_seen = 0;

  task automatic check(input string tag, input logic [MAX_ZC-1:0] got, input logic [MAX_ZC-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MAX_ZC-1:0] gen_col(input int seed, input int c, input int j);
    logic [31:0]       x;
    logic [MAX_ZC-1:0] v;
    x = 32'(seed * 7919 + c * 104729 + j * 613 + 12345);
    for (int i = 0; i < MAX_ZC / 32; i++) begin
      x ^= x << 13;
      x ^= x >> 17;
      x ^= x << 5;
      v[i*32 +: 32] = x;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset_n && tb_valid && tb_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("tb_block", tb_block, e.blk);
        check("tb_last", tb_last, e.last);
        if (e.last) check("tb_last_bits", tb_last_bits, e.bits);
      end
      words_seen++;
    end
  end

  task automatic load_params(input int z, input int k, input int nc, input int kp);
    zc = 9'(z); kb = 5'(k); num_cb = 4'(nc); k_prime = 14'(kp);
    params_valid = 1'b1;
    @(posedge clk); #1;
    params_valid = 1'b0;
  endtask

  task automatic send_col(input logic [MAX_ZC-1:0] blk);
    int waits = 0;
    dec_block = blk;
    dec_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (dec_ready) break;
      waits++;
      if (waits > 500) begin
        check("dec_ready_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    dec_valid = 1'b0;
  endtask

  // Expected words are derived from a plain bit queue, independent of the DUT's accumulator.
  task automatic run_tb(input int z, input int k, input int nc, input int kp, input int seed, input int max_cols);
    int keep, total, sent, n, cols;
    logic [MAX_ZC-1:0] blk;
    exp_t e;
    keep = kp - ((nc > 1) ? CB_CRC_LEN : 0);
    total = nc * keep;
    sent = 0;
    cols = 0;
    model_bits.delete();
    load_params(z, k, nc, kp);
    for (int c = 0; c < nc; c++) begin
      for (int j = 0; j < k; j++) begin
        if (max_cols >= 0 && cols == max_cols) return;
        blk = gen_col(seed, c, j);
        n = keep - j * z;
        if (n < 0) n = 0;
        if (n > z) n = z;
        for (int i = 0; i < n; i++) model_bits.push_back(blk[i]);
        while (model_bits.size() >= MAX_ZC) begin
          for (int i = 0; i < MAX_ZC; i++) e.blk[i] = model_bits.pop_front();
          sent += MAX_ZC;
          e.last = (sent == total);
          e.bits = e.last ? 9'd384 : 9'd0;
          exp_q.push_back(e);
        end
        if (c == nc - 1 && j == k - 1 && model_bits.size() > 0) begin
          e.blk = '0;
          for (int i = 0; i < model_bits.size(); i++) e.blk[i] = model_bits[i];
          e.last = 1'b1;
          e.bits = 9'(model_bits.size());
          model_bits.delete();
          exp_q.push_back(e);
        end
        send_col(blk);
        cols++;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, (t < 5000), 1'b1);
    repeat (3) @(negedge clk);
    check({tag, "_idle_valid"}, tb_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  int bad[4][4] = '{'{384, 22, 1, 9000}, '{0, 22, 1, 100}, '{384, 22, 9, 1000}, '{384, 22, 2, 24}};

  initial begin
    reset_n = 1'b0; params_valid = 1'b0; zc = '0; kb = '0; num_cb = '0; k_prime = '0;
    dec_block = '0; dec_valid = 1'b0; tb_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tb_valid", tb_valid, 1'b0);
    check("rst_tb_block", tb_block, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_dec_ready", dec_ready, 1'b0);
    check("rst_param_err", param_err, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_tb(64, 10, 1, 600, 1, -1);
    wait_done("t1");

    words_seen = 0;
    run_tb(384, 22, 2, 8000, 2, -1);
    wait_done("t2");
    check("t2_words", words_seen, 42);

    words_seen = 0;
    fork
      run_tb(384, 22, 2, 8000, 2, -1);
      begin
        int t = 0;
        logic [MAX_ZC-1:0] held;
        while (!(words_seen >= 8 && tb_valid) && t < 3000) begin
          @(posedge clk); #1;
          t++;
        end
        check("t3_stall_start", (t < 3000), 1'b1);
        tb_ready = 1'b0;
        held = tb_block;
        repeat (10) begin
          @(negedge clk);
          check("t3_stall_block", tb_block, held);
          check("t3_stall_valid", tb_valid, 1'b1);
          check("t3_stall_dec_ready", dec_ready, 1'b0);
        end
        @(posedge clk); #1;
        tb_ready = 1'b1;
      end
    join
    wait_done("t3");
    check("t3_words", words_seen, 42);

    words_seen = 0;
    run_tb(384, 22, 1, 768, 4, -1);
    wait_done("t4");
    check("t4_words", words_seen, 2);

    for (int i = 0; i < 4; i++) begin
      load_params(bad[i][0], bad[i][1], bad[i][2], bad[i][3]);
      @(negedge clk);
      check("t5_param_err", param_err, 1'b1);
      check("t5_busy", busy, 1'b0);
      check("t5_dec_ready", dec_ready, 1'b0);
      @(negedge clk);
      check("t5_param_err_pulse", param_err, 1'b0);
      @(posedge clk); #1;
    end
    load_params(384, 22, 1, 8448);
    @(negedge clk);
    check("t5_max_kp_busy", busy, 1'b1);
    check("t5_max_kp_err", param_err, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    fork
      run_tb(64, 10, 1, 600, 5, -1);
      begin
        repeat (3) @(posedge clk);
        #2;
        check("t5_busy_before_ignore", busy, 1'b1);
        zc = 9'd384; kb = 5'd22; num_cb = 4'd1; k_prime = 14'd768;
        params_valid = 1'b1;
        @(posedge clk); #1;
        params_valid = 1'b0;
        @(negedge clk);
        check("t5_ignored_err", param_err, 1'b0);
      end
    join
    wait_done("t5b");

    run_tb(384, 22, 2, 8000, 6, 5);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_tb_valid", tb_valid, 1'b0);
    check("t6_tb_block", tb_block, '0);
    check("t6_tb_last", tb_last, 1'b0);
    check("t6_tb_last_bits", tb_last_bits, '0);
    check("t6_busy", busy, 1'b0);
    check("t6_dec_ready", dec_ready, 1'b0);
    check("t6_param_err", param_err, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    words_seen = 0;
    run_tb(64, 10, 1, 600, 1, -1);
    wait_done("t6");
    check("t6_words", words_seen, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
